// File: rtl/awaiba_cfg_seq.sv
// ---------------------------------------------------------------------------
// awaiba_cfg_seq
//
// Purpose:
//   Sequencer and arbiter in front of the Awaiba SPI bridge. After a start
//   pulse it plays a sensor init table out of an external synchronous ROM.
//   Between table runs it serves single host register accesses. At most one
//   SPI transaction is outstanding at any time, so spi_address (sensor pair
//   select) never changes while the bridge is still shifting a word out.
//
// Ports:
//   clk           single clock for all logic
//   res           synchronous reset, active high
//   start         pulse: run the init table from entry 0
//   busy          high from start accept until the done pulse
//   done          one-cycle pulse when a table run ends
//   err           sticky read timeout flag, cleared by reset or accepted start
//   tbl_addr      table ROM address
//   tbl_data      ROM entry {dest, reg[7:0], data[7:0]}, valid 1 cycle after tbl_addr
//   host_cmd      host access {dest, reg[7:0], data[7:0]}
//   host_valid    host_cmd valid
//   host_ready    host_cmd accepted when host_valid & host_ready
//   host_rdata    readback byte for a host read
//   host_rvalid   one-cycle pulse qualifying host_rdata
//   spi_data_mo   {reg, data} word to the SPI bridge
//   spi_valid_mo  word valid
//   spi_ready_mo  bridge can accept a word
//   spi_address   sensor pair select to the bridge
//   spi_data_mi   readback byte from the bridge
//   spi_valid_mi  readback valid
//   spi_ready_mi  readback accept, constant 1 after reset
// ---------------------------------------------------------------------------
module awaiba_cfg_seq #(
    parameter int         TBL_AW = 6,
    parameter logic [7:0] RD_REG = 8'd15,
    parameter int         WR_GAP = 64,
    parameter int         RD_TMO = 1023
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [16:0]       tbl_data,
    input  logic [16:0]       host_cmd,
    input  logic              host_valid,
    output logic              host_ready,
    output logic [7:0]        host_rdata,
    output logic              host_rvalid,
    output logic [15:0]       spi_data_mo,
    output logic              spi_valid_mo,
    input  logic              spi_ready_mo,
    output logic              spi_address,
    input  logic [7:0]        spi_data_mi,
    input  logic              spi_valid_mi,
    output logic              spi_ready_mi
);

    // One down-counter serves both the write gap and the read timeout.
    localparam int CNT_MAX = (WR_GAP > RD_TMO) ? WR_GAP : RD_TMO;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [TBL_AW-1:0] TBL_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_WR,
        S_WAIT_RD,
        S_DONE
    } state_t;

    state_t        state;
    logic          fetch_wait;
    logic [CW-1:0] cnt;
    logic          tbl_step;

    // The host may hand over a command only while nothing else is in flight.
    // A start in the same cycle takes precedence, so the host is held off.
    assign host_ready = (state == S_IDLE) && !start && !res;

    // A table transaction has finished this cycle: either the write gap has
    // run out, or the read byte arrived, or the read timed out. busy tells a
    // table transaction apart from a host one.
    always_comb begin
        tbl_step = 1'b0;
        if (busy) begin
            if (state == S_WAIT_WR && cnt == '0)
                tbl_step = 1'b1;
            else if (state == S_WAIT_RD && (spi_valid_mi || cnt == '0))
                tbl_step = 1'b1;
        end
    end

    // Main sequencer. The word to the bridge is latched straight into
    // spi_data_mo/spi_address on ISSUE entry and left untouched until the
    // next ISSUE entry, which keeps both stable across a stalled handshake
    // and across the serial transfer that follows it. The table advance is
    // handled after the case so the write-gap end and both read endings
    // share one path.
    always_ff @(posedge clk) begin
        if (res) begin
            state        <= S_IDLE;
            fetch_wait   <= 1'b0;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            tbl_addr     <= '0;
            host_rdata   <= 8'h00;
            host_rvalid  <= 1'b0;
            spi_data_mo  <= 16'h0000;
            spi_valid_mo <= 1'b0;
            spi_address  <= 1'b0;
            spi_ready_mi <= 1'b0;
        end else begin
            spi_ready_mi <= 1'b1;
            done         <= 1'b0;
            host_rvalid  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        tbl_addr   <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        fetch_wait <= 1'b1;
                        state      <= S_FETCH;
                    end else if (host_valid) begin
                        spi_address  <= host_cmd[16];
                        spi_data_mo  <= host_cmd[15:0];
                        spi_valid_mo <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end

                // First FETCH cycle covers the ROM read latency; the second
                // one looks at the entry.
                S_FETCH: begin
                    if (fetch_wait) begin
                        fetch_wait <= 1'b0;
                    end else if (tbl_data[15:0] == 16'hFFFF) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        spi_address  <= tbl_data[16];
                        spi_data_mo  <= tbl_data[15:0];
                        spi_valid_mo <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (spi_ready_mo) begin
                        spi_valid_mo <= 1'b0;
                        if (spi_data_mo[15:8] == RD_REG) begin
                            cnt   <= CW'(RD_TMO - 1);
                            state <= S_WAIT_RD;
                        end else begin
                            cnt   <= CW'(WR_GAP - 1);
                            state <= S_WAIT_WR;
                        end
                    end
                end

                S_WAIT_WR: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else if (!busy)
                        state <= S_IDLE;
                end

                // Readback byte wins over a timeout landing in the same cycle.
                S_WAIT_RD: begin
                    if (spi_valid_mi) begin
                        if (!busy) begin
                            host_rdata  <= spi_data_mi;
                            host_rvalid <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end else if (cnt == '0) begin
                        err <= 1'b1;
                        if (!busy) begin
                            host_rdata  <= 8'hFF;
                            host_rvalid <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // The last table entry ends the run even without a terminator;
            // tbl_addr never wraps.
            if (tbl_step) begin
                if (tbl_addr == TBL_LAST) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end else begin
                    tbl_addr   <= tbl_addr + 1'b1;
                    fetch_wait <= 1'b1;
                    state      <= S_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_awaiba_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_awaiba_cfg_seq
//
// Purpose:
//   Directed self-checking bench for awaiba_cfg_seq. A small synchronous ROM
//   model feeds the table port; a negedge monitor logs every SPI word
//   handshake together with the sensor pair select.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_awaiba_cfg_seq;

    localparam int G = 8;
    localparam int T = 20;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  tbl_addr;
    logic [16:0] tbl_data;
    logic [16:0] host_cmd = 17'h0;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [7:0]  host_rdata;
    logic        host_rvalid;
    logic [15:0] spi_data_mo;
    logic        spi_valid_mo;
    logic        spi_ready_mo = 1'b1;
    logic        spi_address;
    logic [7:0]  spi_data_mi = 8'h00;
    logic        spi_valid_mi = 1'b0;
    logic        spi_ready_mi;

    logic [16:0] rom [4];
    logic [16:0] word_log [$];
    int          hs_cyc = 0;
    int          ov_cnt = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    awaiba_cfg_seq #(
        .TBL_AW(2),
        .RD_REG(8'd15),
        .WR_GAP(G),
        .RD_TMO(T)
    ) dut (
        .clk(clk),
        .res(res),
        .start(start),
        .busy(busy),
        .done(done),
        .err(err),
        .tbl_addr(tbl_addr),
        .tbl_data(tbl_data),
        .host_cmd(host_cmd),
        .host_valid(host_valid),
        .host_ready(host_ready),
        .host_rdata(host_rdata),
        .host_rvalid(host_rvalid),
        .spi_data_mo(spi_data_mo),
        .spi_valid_mo(spi_valid_mo),
        .spi_ready_mo(spi_ready_mo),
        .spi_address(spi_address),
        .spi_data_mi(spi_data_mi),
        .spi_valid_mi(spi_valid_mi),
        .spi_ready_mi(spi_ready_mi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: data follows the address by one clock.
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // Word log and host-overlap monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (spi_valid_mo && spi_ready_mo) begin
            word_log.push_back({spi_address, spi_data_mo});
            hs_cyc = cyc;
        end
        if (busy && host_ready)
            ov_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (host_ready && !busy) begin
                ok = 1;
                break;
            end
            tick();
        end
        n_checks++;
        if (ok == 0) begin
            n_fail++;
            $display("[TB] FAIL wait_idle: host_ready never rose (got 0, need 1)");
        end
    endtask

    task automatic wait_done(output int seen);
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        res = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy, done, err, host_rvalid, spi_valid_mo, spi_address, host_ready} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b, need 0000000",
                     {busy, done, err, host_rvalid, spi_valid_mo, spi_address, host_ready});
        end
        n_checks++;
        if ({tbl_addr, host_rdata, spi_data_mo} !== 26'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h/%h/%h, need 0/00/0000",
                     tbl_addr, host_rdata, spi_data_mo);
        end
        res = 1'b0;
        tick();
        n_checks++;
        if (spi_ready_mi !== 1'b1 || host_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got ready_mi=%b host_ready=%b, need 1/1",
                     spi_ready_mi, host_ready);
        end
    endtask

    task automatic test_table_run();
        int base;
        int seen;
        wait_idle();
        rom[0] = {1'b0, 16'h0311};
        rom[1] = {1'b1, 16'h0422};
        rom[2] = 17'h0FFFF;
        rom[3] = 17'h00000;
        base = word_log.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL t1_busy: got %b, need 1", busy);
        end
        wait_done(seen);
        n_checks++;
        if (seen == 0) begin
            n_fail++;
            $display("[TB] FAIL t1_done: got no done pulse, need one");
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t1_busy_at_done: got %b, need 0", busy);
        end
        n_checks++;
        if (cyc - hs_cyc !== G + 3) begin
            n_fail++;
            $display("[TB] FAIL t1_gap: got %0d cycles, need %0d", cyc - hs_cyc, G + 3);
        end
        n_checks++;
        if (word_log.size() - base !== 2) begin
            n_fail++;
            $display("[TB] FAIL t1_count: got %0d words, need 2", word_log.size() - base);
        end else begin
            n_checks++;
            if (word_log[base] !== 17'h00311 || word_log[base+1] !== 17'h10422) begin
                n_fail++;
                $display("[TB] FAIL t1_words: got %h %h, need 00311 10422",
                         word_log[base], word_log[base+1]);
            end
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t1_done_pulse: got %b, need 0", done);
        end
    endtask

    task automatic test_host_read();
        int base;
        int got;
        wait_idle();
        base = word_log.size();
        host_cmd = {1'b0, 16'h0F00};
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
        for (int i = 0; i < 50 && word_log.size() == base; i++) tick();
        n_checks++;
        if (word_log.size() != base + 1 || word_log[base] !== 17'h00F00) begin
            n_fail++;
            $display("[TB] FAIL t2_word: got %0d words, need one 00F00", word_log.size() - base);
        end
        tick();
        tick();
        spi_data_mi = 8'h5A;
        spi_valid_mi = 1'b1;
        tick();
        spi_valid_mi = 1'b0;
        spi_data_mi = 8'h00;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (host_rvalid) begin
                got = 1;
                break;
            end
            tick();
        end
        n_checks++;
        if (got == 0 || host_rdata !== 8'h5A || err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t2_rdata: got rv=%0d data=%h err=%b, need 1/5a/0",
                     got, host_rdata, err);
        end
        tick();
        n_checks++;
        if (host_rvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t2_rv_pulse: got %b, need 0", host_rvalid);
        end
        // Stray readback while idle must not disturb anything.
        spi_data_mi = 8'h33;
        spi_valid_mi = 1'b1;
        tick();
        spi_valid_mi = 1'b0;
        tick();
        n_checks++;
        if (host_rvalid !== 1'b0 || host_rdata !== 8'h5A) begin
            n_fail++;
            $display("[TB] FAIL t2_stray: got rv=%b data=%h, need 0/5a", host_rvalid, host_rdata);
        end
    endtask

    task automatic test_read_timeout();
        int got;
        int seen;
        wait_idle();
        host_cmd = {1'b1, 16'h0F77};
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            if (host_rvalid) begin
                got = 1;
                break;
            end
            tick();
        end
        n_checks++;
        if (got == 0 || host_rdata !== 8'hFF || err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL t3_timeout: got rv=%0d data=%h err=%b, need 1/ff/1",
                     got, host_rdata, err);
        end
        n_checks++;
        if (cyc - hs_cyc !== T + 1) begin
            n_fail++;
            $display("[TB] FAIL t3_tmo_len: got %0d cycles, need %0d", cyc - hs_cyc, T + 1);
        end
        tick();
        tick();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL t3_sticky: got %b, need 1", err);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t3_clear: got %b, need 0", err);
        end
        wait_done(seen);
    endtask

    task automatic test_start_priority();
        int base;
        int ov0;
        int seen;
        wait_idle();
        base = word_log.size();
        ov0 = ov_cnt;
        host_cmd = {1'b1, 16'h0533};
        host_valid = 1'b1;
        start = 1'b1;
        #1;
        n_checks++;
        if (host_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t4_ready_at_start: got %b, need 0", host_ready);
        end
        tick();
        start = 1'b0;
        wait_done(seen);
        for (int i = 0; i < 10; i++) begin
            if (host_ready) begin
                tick();
                break;
            end
            tick();
        end
        host_valid = 1'b0;
        for (int i = 0; i < 50 && word_log.size() < base + 3; i++) tick();
        n_checks++;
        if (seen == 0 || ov_cnt != ov0) begin
            n_fail++;
            $display("[TB] FAIL t4_run: got done=%0d overlap=%0d, need 1/0", seen, ov_cnt - ov0);
        end
        n_checks++;
        if (word_log.size() != base + 3) begin
            n_fail++;
            $display("[TB] FAIL t4_count: got %0d words, need 3", word_log.size() - base);
        end else begin
            n_checks++;
            if (word_log[base] !== 17'h00311 || word_log[base+2] !== 17'h10533) begin
                n_fail++;
                $display("[TB] FAIL t4_order: got %h..%h, need 00311..10533",
                         word_log[base], word_log[base+2]);
            end
        end
    endtask

    task automatic test_ready_stall();
        int base;
        int bad;
        wait_idle();
        base = word_log.size();
        spi_ready_mo = 1'b0;
        host_cmd = {1'b1, 16'h07AB};
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (spi_valid_mo !== 1'b1 || spi_data_mo !== 16'h07AB || spi_address !== 1'b1)
                bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL t5_stable: got %0d unstable cycles, need 0", bad);
        end
        spi_ready_mo = 1'b1;
        tick();
        tick();
        n_checks++;
        if (spi_valid_mo !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t5_drop: got valid %b, need 0", spi_valid_mo);
        end
        wait_idle();
        n_checks++;
        if (word_log.size() != base + 1 || word_log[base] !== 17'h107AB) begin
            n_fail++;
            $display("[TB] FAIL t5_once: got %0d words, need one 107ab", word_log.size() - base);
        end
    endtask

    task automatic test_full_table();
        int base;
        int seen;
        wait_idle();
        rom[0] = {1'b0, 16'h0101};
        rom[1] = {1'b1, 16'h0202};
        rom[2] = {1'b0, 16'h0303};
        rom[3] = {1'b1, 16'h0404};
        base = word_log.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(seen);
        n_checks++;
        if (seen == 0 || tbl_addr !== 2'd3) begin
            n_fail++;
            $display("[TB] FAIL t6_done: got done=%0d addr=%0d, need 1/3", seen, tbl_addr);
        end
        n_checks++;
        if (word_log.size() != base + 4) begin
            n_fail++;
            $display("[TB] FAIL t6_count: got %0d words, need 4", word_log.size() - base);
        end else begin
            n_checks++;
            if (word_log[base+2] !== 17'h00303 || word_log[base+3] !== 17'h10404) begin
                n_fail++;
                $display("[TB] FAIL t6_words: got %h %h, need 00303 10404",
                         word_log[base+2], word_log[base+3]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int base;
        wait_idle();
        base = word_log.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && word_log.size() == base; i++) tick();
        tick();
        tick();
        res = 1'b1;
        tick();
        n_checks++;
        if ({busy, done, err, host_rvalid, spi_valid_mo, spi_address, host_ready} !== 7'b0
            || tbl_addr !== 2'd0 || spi_data_mo !== 16'h0000 || host_rdata !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL midrun_reset: got busy=%b valid=%b addr=%0d data=%h, need 0/0/0/0000",
                     busy, spi_valid_mo, tbl_addr, spi_data_mo);
        end
        res = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || host_ready !== 1'b1 || spi_ready_mi !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midrun_idle: got busy=%b ready=%b, need 0/1", busy, host_ready);
        end
    endtask

    // Scenario sequence.
    initial begin
        for (int i = 0; i < 4; i++) rom[i] = 17'h0FFFF;
        test_reset();
        test_table_run();
        test_host_read();
        test_read_timeout();
        test_start_priority();
        test_ready_stall();
        test_full_table();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
